reg_cmd_ctrl: RTL
=================

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: data byte and register width.
REQ-002 The module SHALL have parameter ADDR, default 2: register-file address width.
REQ-003 The module SHALL have parameter TIMEOUT, default 8: maximum read-wait cycles, 2..255.
REQ-004 The module SHALL have port CLK, input, 1: clock; all state updates on rising edge.
REQ-005 The module SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-006 The module SHALL have port RX_P_DATA, input, WIDTH: received command-stream byte.
REQ-007 The module SHALL have port RX_D_VLD, input, 1: RX_P_DATA valid; one byte per high cycle.
REQ-008 The module SHALL have port RdData, input, WIDTH: register-file read data.
REQ-009 The module SHALL have port RdData_VLD, input, 1: register-file read data valid.
REQ-010 The module SHALL have port TX_BUSY, input, 1: transmitter cannot accept a byte.
REQ-011 The module SHALL have port WrEn, output, 1: register-file write strobe.
REQ-012 The module SHALL have port RdEn, output, 1: register-file read strobe.
REQ-013 The module SHALL have port Address, output, ADDR: register-file address.
REQ-014 The module SHALL have port WrData, output, WIDTH: register-file write data.
REQ-015 The module SHALL have port TX_P_DATA, output, WIDTH: byte to transmitter.
REQ-016 The module SHALL have port TX_D_VLD, output, 1: TX_P_DATA valid, one-cycle pulse.
REQ-017 The module SHALL have port CMD_ERR, output, 1: one-cycle error pulse.
REQ-018 The module SHALL have port BUSY, output, 1: high in every state except IDLE.

Function
REQ-019 The module SHALL register all outputs; no output SHALL be combinational from any input.
REQ-020 The module SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-021 In IDLE, a byte 0xAA SHALL move the module to WR_ADDR, and a byte 0xBB SHALL move it to RD_ADDR.
REQ-022 In IDLE, any other byte SHALL pulse CMD_ERR for one cycle, and the module SHALL stay in IDLE.
REQ-023 In WR_ADDR, a byte SHALL latch RX_P_DATA[ADDR-1:0] into Address (upper bits ignored), and the module SHALL move to WR_DATA.
REQ-024 In WR_DATA, a byte SHALL load WrData, assert WrEn for exactly the one cycle after the sampling edge, and return the module to IDLE.
REQ-025 In RD_ADDR, a byte SHALL latch Address, assert RdEn for exactly the one cycle after the sampling edge, and move the module to RD_WAIT.
REQ-026 In RD_WAIT, the module SHALL count cycles from 0; RdData_VLD high SHALL capture RdData into TX_P_DATA and move the module to TX_SEND.
REQ-027 In RD_WAIT, if the count reaches TIMEOUT without RdData_VLD, the module SHALL pulse CMD_ERR and return to IDLE.
REQ-028 In TX_SEND, the module SHALL pulse TX_D_VLD for one cycle at the first edge with TX_BUSY low and return to IDLE; it SHALL wait indefinitely while TX_BUSY is high.
REQ-029 RX_D_VLD in RD_WAIT or TX_SEND SHALL drop the byte and pulse CMD_ERR, with no state change.
REQ-030 WrEn and RdEn SHALL never be high in the same cycle; at most one strobe SHALL be issued per command.
REQ-031 Address and WrData SHALL hold their values between commands.
REQ-032 A 0xAA or 0xBB byte received in a non-IDLE state SHALL be treated as data, not as a command.

Reset
REQ-033 RST low SHALL asynchronously force IDLE, clear the timeout counter, and drive all outputs to 0 (WrEn, RdEn, TX_D_VLD, CMD_ERR, BUSY = 0; Address, WrData, TX_P_DATA = 0).
REQ-034 Reset mid-command SHALL discard the partial command; no strobe SHALL issue after release.
REQ-035 The first RX_D_VLD sampled after release SHALL be decoded as an opcode.

Structure
REQ-036 Opcode constants (0xAA write, 0xBB read) and state encodings SHALL reside in a shared package or include file used by the system top.
REQ-037 The module SHALL be a single module with no sub-modules; the timeout counter SHALL be inline.

Verification
REQ-038 The bench SHALL check: bytes AA, 02, 5C -> WrEn high one cycle with Address=2, WrData=0x5C; BUSY low afterwards.
REQ-039 The bench SHALL check: bytes BB, 03; RdData=0xFF with RdData_VLD 1 cycle after RdEn -> TX_D_VLD pulse with TX_P_DATA=0xFF.
REQ-040 The bench SHALL check: byte 0x37 in IDLE -> CMD_ERR one cycle, no WrEn or RdEn, BUSY stays 0.
REQ-041 The bench SHALL check: bytes BB, 01 with RdData_VLD held 0 -> CMD_ERR exactly TIMEOUT=8 cycles into RD_WAIT, then IDLE.
REQ-042 The bench SHALL check: read with TX_BUSY high for 5 cycles -> TX_D_VLD issued on the first cycle after TX_BUSY falls, once only.
REQ-043 The bench SHALL check: bytes AA, 01, then RST pulse, then 77 -> no WrEn; 77 flagged by CMD_ERR.

Source files
------------

// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared opcode constants and FSM state encoding for the register
// command controller; also imported by the system top.
package reg_cmd_ctrl_pkg;

  localparam logic [7:0] OPC_WRITE = 8'hAA;
  localparam logic [7:0] OPC_READ  = 8'hBB;

  // Timeout counter width: covers TIMEOUT values up to 255.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command decoder: 0xAA addr data writes a register,
// 0xBB addr reads one and forwards the result to the transmitter.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 2,
  parameter int TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             TX_BUSY,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             CMD_ERR,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] OP_WR   = WIDTH'(OPC_WRITE);
  localparam logic [WIDTH-1:0] OP_RD   = WIDTH'(OPC_READ);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   txd_q, txd_d;
  logic               wren_q, wren_d;
  logic               rden_q, rden_d;
  logic               txv_q, txv_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    txv_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (RX_D_VLD) begin
          if (RX_P_DATA == OP_WR)      state_d = ST_WR_ADDR;
          else if (RX_P_DATA == OP_RD) state_d = ST_RD_ADDR;
          else                         err_d   = 1'b1;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_d = RX_P_DATA;
          wren_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          rden_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // A stray byte is dropped but the read keeps waiting.
        if (RX_D_VLD) err_d = 1'b1;
        if (RdData_VLD) begin
          txd_d   = RdData;
          cnt_d   = '0;
          state_d = ST_TX_SEND;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TX_SEND: begin
        if (RX_D_VLD) err_d = 1'b1;
        if (!TX_BUSY) begin
          txv_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign TX_P_DATA = txd_q;
  assign TX_D_VLD  = txv_q;
  assign CMD_ERR   = err_q;
  assign BUSY      = busy_q;

endmodule
